// File: rtl/chacha_arbiter.sv
// chacha_arbiter: two-requester front end for a single chacha_core.
// One keystream job is in flight at a time. The captured block or a timeout
// abort is handed back to the requester that won arbitration.
// Build option: CHACHA_ARB_FIXED_PRIO_EN selects fixed priority (req0 always
// wins). When it is undefined, arbitration is round-robin.
module chacha_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   input  logic [63:0]  req0_ctr,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [63:0]  req1_ctr,
   output logic         req1_ready,
   output logic         resp0_valid,
   input  logic         resp0_ready,
   output logic         resp1_valid,
   input  logic         resp1_ready,
   output logic [511:0] resp_data,
   output logic         resp_err,
   output logic         core_init,
   output logic         core_next,
   output logic [63:0]  core_ctr,
   input  logic         core_ready,
   input  logic         core_data_out_valid,
   input  logic [511:0] core_data_out
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_WAIT, S_RESP} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            r_owner;
   logic [63:0]     r_core_ctr;
   logic [511:0]    r_resp_data;
   logic            r_resp_err;
   logic [CW-1:0]   r_wait_cnt;

   logic            w_win0;
   logic            w_win1;
   logic            w_idle_rdy;
   logic            w_accept0;
   logic            w_accept1;
   logic            w_resp_ready;
   logic            w_timeout;

`ifdef CHACHA_ARB_FIXED_PRIO_EN
   assign w_win0 = req0_valid;
   assign w_win1 = req1_valid & ~req0_valid;
`else
   // r_last_grant = 1 means requester 1 was served last, so requester 0 wins a tie
   logic r_last_grant;

   assign w_win0 = req0_valid & (~req1_valid | r_last_grant);
   assign w_win1 = req1_valid & (~req0_valid | ~r_last_grant);

   // Remember who was granted last so a tie goes to the other requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
      end else if (w_accept0) begin
         r_last_grant <= 1'b0;
      end else if (w_accept1) begin
         r_last_grant <= 1'b1;
      end
   end
`endif

   // Ready is held low while reset is asserted so every output is quiet in reset
   assign w_idle_rdy   = rst_n & (r_state == S_IDLE) & core_ready;
   assign req0_ready   = w_idle_rdy & w_win0;
   assign req1_ready   = w_idle_rdy & w_win1;
   assign w_accept0    = req0_ready;
   assign w_accept1    = req1_ready;
   assign w_resp_ready = r_owner ? resp1_ready : resp0_ready;
   // The last permitted WAIT cycle; a core result in the same cycle still wins
   assign w_timeout    = (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

   assign core_next = 1'b0;
   assign core_ctr  = r_core_ctr;
   assign resp_data = r_resp_data;
   assign resp_err  = r_resp_err;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and state-decoded outputs
   always_comb begin
      w_state_next = r_state;
      core_init    = 1'b0;
      resp0_valid  = 1'b0;
      resp1_valid  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept0 || w_accept1) begin
               w_state_next = S_INIT;
            end
         end
         S_INIT: begin
            core_init    = 1'b1;
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (core_data_out_valid || w_timeout) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            resp0_valid = ~r_owner;
            resp1_valid = r_owner;
            if (w_resp_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Job datapath: capture counter/owner on acceptance, result or abort in WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner     <= 1'b0;
         r_core_ctr  <= '0;
         r_resp_data <= '0;
         r_resp_err  <= 1'b0;
         r_wait_cnt  <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept0) begin
                  r_core_ctr <= req0_ctr;
                  r_owner    <= 1'b0;
               end else if (w_accept1) begin
                  r_core_ctr <= req1_ctr;
                  r_owner    <= 1'b1;
               end
            end
            S_INIT: begin
               r_wait_cnt <= '0;
            end
            S_WAIT: begin
               if (core_data_out_valid) begin
                  r_resp_data <= core_data_out;
                  r_resp_err  <= 1'b0;
               end else begin
                  if (r_wait_cnt != CW'(TIMEOUT_CYCLES)) begin
                     r_wait_cnt <= r_wait_cnt + 1'b1;
                  end
                  if (w_timeout) begin
                     r_resp_err <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chacha_arbiter.sv
// Self-checking bench for chacha_arbiter with a behavioural chacha_core stand-in.
// Expected owner, latency, data and error flag come from the arbitration and
// timing rules, tracked here as plain variables per job.
module tb_chacha_arbiter;

   localparam int TMO = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0;
   logic [63:0]  req0_ctr = '0;
   logic         req0_ready;
   logic         req1_valid = 1'b0;
   logic [63:0]  req1_ctr = '0;
   logic         req1_ready;
   logic         resp0_valid;
   logic         resp0_ready = 1'b0;
   logic         resp1_valid;
   logic         resp1_ready = 1'b0;
   logic [511:0] resp_data;
   logic         resp_err;
   logic         core_init;
   logic         core_next;
   logic [63:0]  core_ctr;
   logic         core_ready = 1'b1;
   logic         core_data_out_valid;
   logic [511:0] core_data_out;

   int total = 0;
   int bad   = 0;

   // Reference state
   bit           m_last = 1'b1;     // 1: requester 1 served last
   logic [511:0] m_data = '0;       // block the DUT should currently be holding

   // Core stand-in: returns m_blk m_lat cycles into WAIT; m_lat < 0 means never
   int           m_lat = -1;
   logic [511:0] m_blk = '0;
   int           m_cnt = -1;
   int           init_cnt = 0;

   chacha_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ctr(req0_ctr), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_ctr(req1_ctr), .req1_ready(req1_ready),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_data(resp_data), .resp_err(resp_err),
      .core_init(core_init), .core_next(core_next), .core_ctr(core_ctr),
      .core_ready(core_ready), .core_data_out_valid(core_data_out_valid),
      .core_data_out(core_data_out)
   );

   always #5 clk = ~clk;

   assign core_data_out_valid = (m_cnt == 0);
   assign core_data_out       = core_data_out_valid ? m_blk : ~m_blk;

   always @(posedge clk) begin
      if (core_init) begin
         init_cnt <= init_cnt + 1;
         m_cnt    <= m_lat;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
      end else begin
         m_cnt <= -1;
      end
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Starts and ends just after a negedge with the DUT idle
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_core_init", core_init, 1'b0);
      chk("rst_core_next", core_next, 1'b0);
      chk("rst_resp_valid", {resp0_valid, resp1_valid}, 2'b00);
      chk("rst_resp_err", resp_err, 1'b0);
      chk("rst_core_ctr", core_ctr, 64'd0);
      chk("rst_resp_data", resp_data, 512'd0);
      chk("rst_req_ready", {req0_ready, req1_ready}, 2'b00);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      m_last = 1'b1;
      m_data = '0;
   endtask

   // One full job: arbitration, INIT, WAIT, RESP with optional backpressure
   task automatic run_job(input bit v0, input bit v1, input logic [63:0] c0,
                          input logic [63:0] c1, input int lat, input int hold,
                          input bit keep);
      int owner, n, n_exp, init_b;
      bit err_exp, seen;
      logic [63:0] ctr_exp;
      logic [511:0] blk;
      blk = rand512();
`ifdef CHACHA_ARB_FIXED_PRIO_EN
      owner = v0 ? 0 : 1;
`else
      owner = (v0 && v1) ? (m_last ? 0 : 1) : (v0 ? 0 : 1);
`endif
      ctr_exp = (owner == 0) ? c0 : c1;
      err_exp = (lat < 0) || (lat >= TMO);
      n_exp   = err_exp ? TMO + 2 : lat + 3;
      req0_valid = v0; req1_valid = v1; req0_ctr = c0; req1_ctr = c1;
      m_lat = lat; m_blk = blk;
      #1;
      chk("req0_ready", req0_ready, owner == 0);
      chk("req1_ready", req1_ready, owner == 1);
      init_b = init_cnt;
      @(negedge clk);
      if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      chk("core_init", core_init, 1'b1);
      chk("core_ctr", core_ctr, ctr_exp);
      n = 1; seen = 1'b0;
      while (!seen && n < TMO + 40) begin
         @(negedge clk);
         n++;
         if (resp0_valid || resp1_valid) seen = 1'b1;
         else chk("busy_quiet", {req0_ready, req1_ready, core_init}, 3'b000);
      end
      if (!err_exp) m_data = blk;
      m_last = (owner == 1);
      chk("resp_seen", seen, 1'b1);
      chk("resp_latency", n, n_exp);
      chk("resp0_valid", resp0_valid, owner == 0);
      chk("resp1_valid", resp1_valid, owner == 1);
      chk("resp_data", resp_data, m_data);
      chk("resp_err", resp_err, err_exp);
      chk("core_ctr_hold", core_ctr, ctr_exp);
      chk("init_pulses", init_cnt - init_b, 1);
      for (int i = 0; i < hold; i++) begin
         if (owner == 0) req1_valid = 1'b1; else req0_valid = 1'b1;
         #1;
         chk("bp_valid", {resp0_valid, resp1_valid}, (owner == 0) ? 2'b10 : 2'b01);
         chk("bp_data", resp_data, m_data);
         chk("bp_err", resp_err, err_exp);
         chk("bp_no_accept", {req0_ready, req1_ready}, 2'b00);
         @(negedge clk);
      end
      if (owner == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
      req0_valid = keep & v0; req1_valid = keep & v1;
      @(negedge clk);
      chk("idle_after", {resp0_valid, resp1_valid}, 2'b00);
      chk("init_total", init_cnt - init_b, 1);
      resp0_ready = 1'b0; resp1_ready = 1'b0;
      $display("job owner=%0d ctr=%0h lat=%0d err=%0b latency=%0d hold=%0d",
               owner, ctr_exp, lat, err_exp, n, hold);
   endtask

   initial begin
      int init_b;
      bit v0, v1;
      @(negedge clk);
      do_reset();

      // Single request, result 10 cycles after the init pulse
      run_job(1'b1, 1'b0, 64'd0, 64'd0, 9, 0, 1'b0);

      // Simultaneous requests held valid: round-robin 0,1,0,1
      do_reset();
      for (int i = 0; i < 4; i++) run_job(1'b1, 1'b1, 64'd5, 64'd9, 2, 0, i < 3);

      // Timeout: core never answers
      run_job(1'b1, 1'b0, 64'h1234, 64'd0, -1, 0, 1'b0);

      // Backpressure on requester 1 for 50 cycles
      run_job(1'b0, 1'b1, 64'd0, 64'hABCD, 4, 50, 1'b0);

      // core_ready low in IDLE blocks acceptance
      core_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
      init_b = init_cnt;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("core_busy_no_ready", {req0_ready, req1_ready}, 2'b00);
         @(negedge clk);
      end
      chk("core_busy_no_init", init_cnt, init_b);
      $display("core_ready low held 5 cycles, inits=%0d", init_cnt - init_b);
      core_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;

      // Reset during WAIT abandons the job; pending req1 then gets a fresh init
      req0_valid = 1'b1; req0_ctr = 64'h77; m_lat = -1;
      @(negedge clk);
      req0_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("wait_no_resp", {resp0_valid, resp1_valid, core_init}, 3'b000);
      req1_valid = 1'b1; req1_ctr = 64'h99;
      do_reset();
      $display("reset during WAIT applied and released");
      run_job(1'b0, 1'b1, 64'd0, 64'h99, 1, 0, 1'b0);

      // Randomized jobs
      for (int k = 0; k < 10; k++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v0 = 1'b1;
         run_job(v0, v1, {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 20)),
                 int'($urandom_range(0, 3)), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
